// File: rtl/slot_table_ctrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// slot_table_ctrl_pkg : op/status codes and FSM states for the slot table
// Rev 1.0
//------------------------------------------------------------------------------
package slot_table_ctrl_pkg;

   localparam int DEFAULT_N_SLOTS = 20;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_DEL = 2'b01,
      OP_CLR = 2'b10,
      OP_RSV = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_OK   = 2'b00,
      ST_DUP  = 2'b01,
      ST_FULL = 2'b10,
      ST_MISS = 2'b11
   } status_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_SCAN = 2'b01,
      S_RESP = 2'b10
   } state_e;

endpackage
`default_nettype wire

// File: rtl/slot_table_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// slot_table_ctrl : sole writer of the hit-checker slot table (ADD/DEL/CLR)
// Rev 1.0
//------------------------------------------------------------------------------
module slot_table_ctrl
   import slot_table_ctrl_pkg::*;
#(
   parameter int N_SLOTS = DEFAULT_N_SLOTS,
   parameter int COORD_W = 1,
   parameter int IDX_W   = 5
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [1:0]                 cmd_op,
   input  logic [COORD_W-1:0]         cmd_x,
   input  logic [COORD_W-1:0]         cmd_y,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [1:0]                 rsp_status,
   output logic [IDX_W-1:0]           rsp_idx,
   output logic [N_SLOTS*COORD_W-1:0] arr_x,
   output logic [N_SLOTS*COORD_W-1:0] arr_y,
   output logic [N_SLOTS-1:0]         arr_en,
   output logic [IDX_W:0]             occupancy
);

   state_e                            state_q, state_d;
   op_e                               op_q, op_d;
   status_e                           status_q, status_d;
   logic [COORD_W-1:0]                x_q, x_d, y_q, y_d;
   logic [IDX_W-1:0]                  idx_q, idx_d;
   logic [IDX_W-1:0]                  free_idx_q, free_idx_d;
   logic [IDX_W-1:0]                  clr_idx_q, clr_idx_d;
   logic [IDX_W-1:0]                  rsp_idx_q, rsp_idx_d;
   logic                              free_found_q, free_found_d;
   logic                              dup_q, dup_d;
   logic                              cleared_q, cleared_d;
   logic [N_SLOTS-1:0][COORD_W-1:0]   tab_x_q, tab_x_d, tab_y_q, tab_y_d;
   logic [N_SLOTS-1:0]                en_q, en_d;
   logic [IDX_W:0]                    occ_q, occ_d;

   logic                              sel_en;
   logic [COORD_W-1:0]                sel_x, sel_y;
   logic                              hit;
   logic                              last;

   // Slot currently visited by the scan
   always_comb begin
      sel_en = 1'b0;
      sel_x  = '0;
      sel_y  = '0;
      for (int i = 0; i < N_SLOTS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            sel_en = en_q[i];
            sel_x  = tab_x_q[i];
            sel_y  = tab_y_q[i];
         end
      end
   end

   assign hit  = sel_en && (sel_x == x_q) && (sel_y == y_q);
   assign last = (idx_q == IDX_W'(N_SLOTS - 1));

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      status_d     = status_q;
      x_d          = x_q;
      y_d          = y_q;
      idx_d        = idx_q;
      free_idx_d   = free_idx_q;
      clr_idx_d    = clr_idx_q;
      rsp_idx_d    = rsp_idx_q;
      free_found_d = free_found_q;
      dup_d        = dup_q;
      cleared_d    = cleared_q;
      tab_x_d      = tab_x_q;
      tab_y_d      = tab_y_q;
      en_d         = en_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d = op_e'(cmd_op);
               x_d  = cmd_x;
               y_d  = cmd_y;
               if (cmd_op == OP_ADD || cmd_op == OP_DEL) begin
                  state_d      = S_SCAN;
                  idx_d        = '0;
                  free_found_d = 1'b0;
                  free_idx_d   = '0;
                  dup_d        = 1'b0;
                  cleared_d    = 1'b0;
                  clr_idx_d    = '0;
               end else begin
                  en_d      = '0;
                  status_d  = ST_OK;
                  rsp_idx_d = '0;
                  state_d   = S_RESP;
               end
            end
         end

         S_SCAN: begin
            if (!last) begin
               idx_d = idx_q + 1'b1;
            end
            if (op_q == OP_ADD) begin
               if (hit) begin
                  dup_d = 1'b1;
               end
               if (!sel_en && !free_found_q) begin
                  free_found_d = 1'b1;
                  free_idx_d   = idx_q;
               end
               // Resolution uses the _d flags so the final slot is included
               if (last) begin
                  state_d   = S_RESP;
                  rsp_idx_d = '0;
                  if (dup_d) begin
                     status_d = ST_DUP;
                  end else if (free_found_d) begin
                     status_d  = ST_OK;
                     rsp_idx_d = free_idx_d;
                     for (int i = 0; i < N_SLOTS; i++) begin
                        if (free_idx_d == IDX_W'(i)) begin
                           tab_x_d[i] = x_q;
                           tab_y_d[i] = y_q;
                           en_d[i]    = 1'b1;
                        end
                     end
                  end else begin
                     status_d = ST_FULL;
                  end
               end
            end else begin
               if (hit) begin
                  for (int i = 0; i < N_SLOTS; i++) begin
                     if (idx_q == IDX_W'(i)) begin
                        en_d[i] = 1'b0;
                     end
                  end
                  if (!cleared_q) begin
                     clr_idx_d = idx_q;
                  end
                  cleared_d = 1'b1;
               end
               if (last) begin
                  state_d = S_RESP;
                  if (cleared_d) begin
                     status_d  = ST_OK;
                     rsp_idx_d = clr_idx_d;
                  end else begin
                     status_d  = ST_MISS;
                     rsp_idx_d = '0;
                  end
               end
            end
         end

         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Occupancy tracks the next enable vector so both update on the same edge
   always_comb begin
      occ_d = '0;
      for (int i = 0; i < N_SLOTS; i++) begin
         occ_d = occ_d + (IDX_W + 1)'(en_d[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         op_q         <= OP_ADD;
         status_q     <= ST_OK;
         x_q          <= '0;
         y_q          <= '0;
         idx_q        <= '0;
         free_idx_q   <= '0;
         clr_idx_q    <= '0;
         rsp_idx_q    <= '0;
         free_found_q <= 1'b0;
         dup_q        <= 1'b0;
         cleared_q    <= 1'b0;
         tab_x_q      <= '0;
         tab_y_q      <= '0;
         en_q         <= '0;
         occ_q        <= '0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         status_q     <= status_d;
         x_q          <= x_d;
         y_q          <= y_d;
         idx_q        <= idx_d;
         free_idx_q   <= free_idx_d;
         clr_idx_q    <= clr_idx_d;
         rsp_idx_q    <= rsp_idx_d;
         free_found_q <= free_found_d;
         dup_q        <= dup_d;
         cleared_q    <= cleared_d;
         tab_x_q      <= tab_x_d;
         tab_y_q      <= tab_y_d;
         en_q         <= en_d;
         occ_q        <= occ_d;
      end
   end

   assign cmd_ready  = (state_q == S_IDLE);
   assign rsp_valid  = (state_q == S_RESP);
   assign rsp_status = status_q;
   assign rsp_idx    = rsp_idx_q;
   assign arr_x      = tab_x_q;
   assign arr_y      = tab_y_q;
   assign arr_en     = en_q;
   assign occupancy  = occ_q;

endmodule
`default_nettype wire
